// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD run controller:
//   - run-sequencer state encoding
//   - register word offsets (byte address bits [7:3])
//   - CTRL / STATUS bit positions
//   - byte-lane merge helper for byte-enabled register writes
// -----------------------------------------------------------------------------
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    // Register word indices.
    localparam logic [4:0] WORD_CTRL   = 5'd0;
    localparam logic [4:0] WORD_STATUS = 5'd1;
    localparam logic [4:0] WORD_LIM    = 5'd2;
    localparam logic [4:0] WORD_CYCLES = 5'd3;
    localparam logic [4:0] WORD_RUNS   = 5'd4;

    // CTRL bits.
    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bits; [4:1] are the sticky write-1-to-clear flags.
    localparam int STS_BUSY      = 0;
    localparam int STS_DONE      = 1;
    localparam int STS_TIMEOUT   = 2;
    localparam int STS_ABORT     = 3;
    localparam int STS_START_ERR = 4;
    localparam int STS_STATE_LO  = 8;

    // Replace each byte of old_word whose active-low enable is 0 with new_word.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  wben_n);
        logic [63:0] merged;
        merged = old_word;
        for (int b = 0; b < 8; b++) begin
            if (!wben_n[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/gcd_ctrl_regs.sv
// -----------------------------------------------------------------------------
// gcd_ctrl_regs
// Bus-facing register block of the GCD run controller.
//   i_clk, i_reset              : clock, synchronous active-high reset
//   i_cen_n/i_addr/i_wdata/
//   i_wen_n/i_wben_n            : SRAM-style slave bus (active-low strobes)
//   o_rdata                     : registered read data
//   i_state/i_cycles/i_runs     : live values from the sequencer (read-only)
//   i_set_*                     : one-cycle set requests for sticky flags
//   o_start_req/o_abort_req     : decoded CTRL write-1 pulses (combinational)
//   o_lim                       : timeout limit
//   o_irq                       : registered interrupt level
// -----------------------------------------------------------------------------
module gcd_ctrl_regs #(
    parameter int TIMEOUT_W = 32,
    parameter int RUNCNT_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cen_n,
    input  logic [7:0]           i_addr,
    input  logic [63:0]          i_wdata,
    input  logic                 i_wen_n,
    input  logic [7:0]           i_wben_n,
    output logic [63:0]          o_rdata,
    input  logic [1:0]           i_state,
    input  logic [TIMEOUT_W-1:0] i_cycles,
    input  logic [RUNCNT_W-1:0]  i_runs,
    input  logic                 i_set_done,
    input  logic                 i_set_timeout,
    input  logic                 i_set_abort,
    input  logic                 i_set_start_err,
    output logic                 o_start_req,
    output logic                 o_abort_req,
    output logic [TIMEOUT_W-1:0] o_lim,
    output logic                 o_irq
);
    import gcd_pkg::*;

    logic                 r_irq_en;
    logic [TIMEOUT_W-1:0] r_lim;
    logic                 r_done_s;
    logic                 r_timeout_s;
    logic                 r_abort_s;
    logic                 r_start_err;
    logic                 r_irq;
    logic [63:0]          r_rdata;

    logic                 w_wr;
    logic                 w_rd;
    logic [4:0]           w_word;
    logic                 w_ctrl_wr;
    logic                 w_status_wr;
    logic [3:0]           w_w1c;
    logic [63:0]          w_lim_merged;
    logic [63:0]          w_rd_word;
    logic                 w_unused;

    // Bus decode: strobes, CTRL pulses (byte 0 only), W1C mask, merged LIM.
    always_comb begin
        w_wr         = !i_cen_n && !i_wen_n;
        w_rd         = !i_cen_n &&  i_wen_n;
        w_word       = i_addr[7:3];
        w_ctrl_wr    = w_wr && (w_word == WORD_CTRL)   && !i_wben_n[0];
        w_status_wr  = w_wr && (w_word == WORD_STATUS) && !i_wben_n[0];
        if (w_status_wr) begin
            w_w1c = i_wdata[STS_START_ERR:STS_DONE];
        end else begin
            w_w1c = 4'b0000;
        end
        w_lim_merged = byte_merge(64'(r_lim), i_wdata, i_wben_n);
        o_start_req  = w_ctrl_wr && i_wdata[CTRL_START];
        o_abort_req  = w_ctrl_wr && i_wdata[CTRL_ABORT];
    end

    // Read mux: unmapped words return zero.
    always_comb begin
        w_rd_word = 64'd0;
        case (w_word)
            WORD_CTRL: begin
                w_rd_word[CTRL_IRQ_EN] = r_irq_en;
            end
            WORD_STATUS: begin
                w_rd_word[STS_BUSY]      = (i_state != ST_IDLE);
                w_rd_word[STS_DONE]      = r_done_s;
                w_rd_word[STS_TIMEOUT]   = r_timeout_s;
                w_rd_word[STS_ABORT]     = r_abort_s;
                w_rd_word[STS_START_ERR] = r_start_err;
                w_rd_word[STS_STATE_LO +: 2] = i_state;
            end
            WORD_LIM:    w_rd_word = 64'(r_lim);
            WORD_CYCLES: w_rd_word = 64'(i_cycles);
            WORD_RUNS:   w_rd_word = 64'(i_runs);
            default:     w_rd_word = 64'd0;
        endcase
    end

    // Register state: config, sticky flags (set beats clear), IRQ, read data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq_en    <= 1'b0;
            r_lim       <= {TIMEOUT_W{1'b0}};
            r_done_s    <= 1'b0;
            r_timeout_s <= 1'b0;
            r_abort_s   <= 1'b0;
            r_start_err <= 1'b0;
            r_irq       <= 1'b0;
            r_rdata     <= 64'd0;
        end else begin
            if (w_ctrl_wr) begin
                r_irq_en <= i_wdata[CTRL_IRQ_EN];
            end
            if (w_wr && (w_word == WORD_LIM)) begin
                r_lim <= w_lim_merged[TIMEOUT_W-1:0];
            end
            r_done_s    <= i_set_done      | (r_done_s    & ~w_w1c[0]);
            r_timeout_s <= i_set_timeout   | (r_timeout_s & ~w_w1c[1]);
            r_abort_s   <= i_set_abort     | (r_abort_s   & ~w_w1c[2]);
            r_start_err <= i_set_start_err | (r_start_err & ~w_w1c[3]);
            r_irq       <= r_irq_en & (r_done_s | r_timeout_s | r_abort_s);
            if (w_rd) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    // Address bits [2:0] select nothing; upper merged bits beyond the limit width are dropped.
    assign w_unused = ^{i_addr[2:0], w_lim_merged};

    assign o_rdata = r_rdata;
    assign o_lim   = r_lim;
    assign o_irq   = r_irq;

endmodule

// File: rtl/gcd_run_ctrl.sv
// -----------------------------------------------------------------------------
// gcd_run_ctrl
// Run controller for the GCD accelerator: launches the core, detects
// completion on the rising edge of DONE, enforces an optional timeout, handles
// abort, and keeps cycle/run counters. Registers live in gcd_ctrl_regs.
//   CLK, RESET          : clock, synchronous active-high reset
//   SRAM_*              : SRAM-style slave bus, registered read data
//   GCD_START/GCD_CLR   : one-cycle launch / clear pulses to the core
//   DONE                : core completion level
//   ARGS_LOCKED         : high while a run is in flight
//   IRQ                 : registered interrupt level
// -----------------------------------------------------------------------------
module gcd_run_ctrl #(
    parameter int TIMEOUT_W = 32,
    parameter int RUNCNT_W  = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SRAM_CEn,
    input  logic [7:0]  SRAM_ADDR,
    input  logic [63:0] SRAM_WDATA,
    input  logic        SRAM_WEn,
    input  logic [7:0]  SRAM_WBEn,
    output logic [63:0] SRAM_RDATA,
    output logic        GCD_START,
    output logic        GCD_CLR,
    input  logic        DONE,
    output logic        ARGS_LOCKED,
    output logic        IRQ
);
    import gcd_pkg::*;

    localparam logic [TIMEOUT_W-1:0] CYC_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [RUNCNT_W-1:0]  RUN_ONE = {{(RUNCNT_W-1){1'b0}}, 1'b1};

    state_e               r_state;
    state_e               w_state_nxt;
    logic                 r_done_q;
    logic                 r_abort_pend;
    logic                 r_gcd_start;
    logic                 r_gcd_clr;
    logic [TIMEOUT_W-1:0] r_cycles;
    logic [RUNCNT_W-1:0]  r_runs;

    logic                 w_start_req;
    logic                 w_abort_req;
    logic [TIMEOUT_W-1:0] w_lim;
    logic                 w_done_rise;
    logic                 w_abort;
    logic                 w_timeout;
    logic                 w_launch;
    logic                 w_clr;
    logic                 w_set_done;
    logic                 w_set_timeout;
    logic                 w_set_abort;
    logic                 w_set_start_err;
    logic                 w_cyc_clear;
    logic                 w_cyc_inc;
    logic                 w_run_inc;

    gcd_ctrl_regs #(
        .TIMEOUT_W (TIMEOUT_W),
        .RUNCNT_W  (RUNCNT_W)
    ) u_regs (
        .i_clk           (CLK),
        .i_reset         (RESET),
        .i_cen_n         (SRAM_CEn),
        .i_addr          (SRAM_ADDR),
        .i_wdata         (SRAM_WDATA),
        .i_wen_n         (SRAM_WEn),
        .i_wben_n        (SRAM_WBEn),
        .o_rdata         (SRAM_RDATA),
        .i_state         (r_state),
        .i_cycles        (r_cycles),
        .i_runs          (r_runs),
        .i_set_done      (w_set_done),
        .i_set_timeout   (w_set_timeout),
        .i_set_abort     (w_set_abort),
        .i_set_start_err (w_set_start_err),
        .o_start_req     (w_start_req),
        .o_abort_req     (w_abort_req),
        .o_lim           (w_lim),
        .o_irq           (IRQ)
    );

    // Next-state and action decode; WAIT exit priority is done > abort > timeout.
    always_comb begin
        w_state_nxt     = r_state;
        w_launch        = 1'b0;
        w_clr           = 1'b0;
        w_set_done      = 1'b0;
        w_set_timeout   = 1'b0;
        w_set_abort     = 1'b0;
        w_set_start_err = 1'b0;
        w_cyc_clear     = 1'b0;
        w_cyc_inc       = 1'b0;
        w_run_inc       = 1'b0;
        w_done_rise     = DONE && !r_done_q;
        // An abort written during LAUNCH is held one cycle and acts in the first WAIT cycle.
        w_abort         = w_abort_req || r_abort_pend;
        w_timeout       = (w_lim != {TIMEOUT_W{1'b0}}) && (r_cycles == (w_lim - CYC_ONE));
        case (r_state)
            ST_IDLE: begin
                if (w_start_req) begin
                    w_state_nxt = ST_LAUNCH;
                    w_launch    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                w_state_nxt     = ST_WAIT;
                w_cyc_clear     = 1'b1;
                w_set_start_err = w_start_req;
            end
            ST_WAIT: begin
                w_set_start_err = w_start_req;
                if (w_done_rise) begin
                    // The completion cycle itself is not counted.
                    w_state_nxt = ST_IDLE;
                    w_set_done  = 1'b1;
                    w_run_inc   = 1'b1;
                end else begin
                    w_cyc_inc = 1'b1;
                    if (w_abort) begin
                        w_state_nxt = ST_IDLE;
                        w_set_abort = 1'b1;
                        w_clr       = 1'b1;
                    end else if (w_timeout) begin
                        w_state_nxt   = ST_IDLE;
                        w_set_timeout = 1'b1;
                        w_clr         = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output pulses, DONE history, pending abort and counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_done_q     <= 1'b0;
            r_abort_pend <= 1'b0;
            r_gcd_start  <= 1'b0;
            r_gcd_clr    <= 1'b0;
            r_cycles     <= {TIMEOUT_W{1'b0}};
            r_runs       <= {RUNCNT_W{1'b0}};
        end else begin
            r_done_q     <= DONE;
            r_abort_pend <= (r_state == ST_LAUNCH) && w_abort_req;
            r_gcd_start  <= w_launch;
            r_gcd_clr    <= w_clr;
            if (w_cyc_clear) begin
                r_cycles <= {TIMEOUT_W{1'b0}};
            end else if (w_cyc_inc && (r_cycles != {TIMEOUT_W{1'b1}})) begin
                r_cycles <= r_cycles + CYC_ONE;
            end
            if (w_run_inc) begin
                r_runs <= r_runs + RUN_ONE;
            end
        end
    end

    assign GCD_START   = r_gcd_start;
    assign GCD_CLR     = r_gcd_clr;
    assign ARGS_LOCKED = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gcd_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gcd_run_ctrl
// Scenario-per-task bench for gcd_run_ctrl. Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_gcd_run_ctrl;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h08;
    localparam logic [7:0] A_LIM    = 8'h10;
    localparam logic [7:0] A_CYCLES = 8'h18;
    localparam logic [7:0] A_RUNS   = 8'h20;

    logic        CLK;
    logic        RESET;
    logic        SRAM_CEn;
    logic [7:0]  SRAM_ADDR;
    logic [63:0] SRAM_WDATA;
    logic        SRAM_WEn;
    logic [7:0]  SRAM_WBEn;
    logic [63:0] SRAM_RDATA;
    logic        GCD_START;
    logic        GCD_CLR;
    logic        DONE;
    logic        ARGS_LOCKED;
    logic        IRQ;

    int checks;
    int errors;
    int exp_runs;

    gcd_run_ctrl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SRAM_CEn    (SRAM_CEn),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_WDATA  (SRAM_WDATA),
        .SRAM_WEn    (SRAM_WEn),
        .SRAM_WBEn   (SRAM_WBEn),
        .SRAM_RDATA  (SRAM_RDATA),
        .GCD_START   (GCD_START),
        .GCD_CLR     (GCD_CLR),
        .DONE        (DONE),
        .ARGS_LOCKED (ARGS_LOCKED),
        .IRQ         (IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d, input logic [7:0] be_n);
        SRAM_CEn   = 1'b0;
        SRAM_WEn   = 1'b0;
        SRAM_ADDR  = a;
        SRAM_WDATA = d;
        SRAM_WBEn  = be_n;
        tick();
        SRAM_CEn   = 1'b1;
        SRAM_WEn   = 1'b1;
        SRAM_WBEn  = 8'hFF;
    endtask

    task automatic rd(input logic [7:0] a, output logic [63:0] d);
        SRAM_CEn  = 1'b0;
        SRAM_WEn  = 1'b1;
        SRAM_ADDR = a;
        tick();
        SRAM_CEn  = 1'b1;
        d = SRAM_RDATA;
    endtask

    task automatic test_reset();
        logic [63:0] v;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        checks++;
        if ({GCD_START, GCD_CLR, IRQ, ARGS_LOCKED} !== 4'b0000 || SRAM_RDATA !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs got start/clr/irq/lock=%b rdata=%h exp 0000/0", {GCD_START, GCD_CLR, IRQ, ARGS_LOCKED}, SRAM_RDATA);
        end
        rd(A_STATUS, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL reset_status got %h exp 0", v); end
        rd(A_RUNS, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL reset_runs got %h exp 0", v); end
    endtask

    // Completion k WAIT cycles after launch.
    task automatic test_done_run(input int k);
        logic [63:0] v;
        int starts;
        DONE = 1'b0;
        wr(A_LIM, 64'd0, 8'h00);
        wr(A_CTRL, 64'h4, 8'h00);
        wr(A_CTRL, 64'h5, 8'h00);
        checks++;
        if (GCD_START !== 1'b1 || ARGS_LOCKED !== 1'b1) begin
            errors++; $display("FAIL launch_cycle got start=%b lock=%b exp 1/1", GCD_START, ARGS_LOCKED);
        end
        starts = 1;
        for (int i = 0; i <= k; i++) begin
            tick();
            if (GCD_START === 1'b1) starts++;
        end
        DONE = 1'b1;
        tick();
        checks++;
        if (ARGS_LOCKED !== 1'b0 || GCD_CLR !== 1'b0 || IRQ !== 1'b0) begin
            errors++; $display("FAIL done_exit got lock=%b clr=%b irq=%b exp 0/0/0", ARGS_LOCKED, GCD_CLR, IRQ);
        end
        tick();
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL done_irq got %b exp 1", IRQ); end
        checks++;
        if (starts !== 1) begin errors++; $display("FAIL start_pulse_count got %0d exp 1", starts); end
        exp_runs++;
        rd(A_CYCLES, v);
        checks++;
        if (v !== 64'(k)) begin errors++; $display("FAIL done_cycles got %0d exp %0d", v, k); end
        rd(A_STATUS, v);
        checks++;
        if (v !== 64'h2) begin errors++; $display("FAIL done_status got %h exp 2", v); end
        rd(A_RUNS, v);
        checks++;
        if (v !== 64'(exp_runs)) begin errors++; $display("FAIL done_runs got %0d exp %0d", v, exp_runs); end
        wr(A_STATUS, 64'h2, 8'h00);
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL w1c_irq_hold got %b exp 1", IRQ); end
        tick();
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop got %b exp 0", IRQ); end
        DONE = 1'b0;
        tick();
    endtask

    task automatic test_timeout(input int lim);
        logic [63:0] v;
        int clrs;
        int locked;
        DONE = 1'b0;
        wr(A_LIM, 64'(lim), 8'h00);
        wr(A_CTRL, 64'h5, 8'h00);
        clrs = 0;
        locked = 0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (ARGS_LOCKED === 1'b1) locked++;
            if (GCD_CLR === 1'b1) clrs++;
        end
        tick();
        checks++;
        if (GCD_CLR !== 1'b1 || ARGS_LOCKED !== 1'b0 || locked !== lim) begin
            errors++; $display("FAIL timeout_exit got clr=%b lock=%b wait_cycles=%0d exp 1/0/%0d", GCD_CLR, ARGS_LOCKED, locked, lim);
        end
        for (int i = 0; i < 4; i++) begin
            if (GCD_CLR === 1'b1) clrs++;
            tick();
        end
        checks++;
        if (clrs !== 1) begin errors++; $display("FAIL timeout_clr_count got %0d exp 1", clrs); end
        rd(A_CYCLES, v);
        checks++;
        if (v !== 64'(lim)) begin errors++; $display("FAIL timeout_cycles got %0d exp %0d", v, lim); end
        rd(A_STATUS, v);
        checks++;
        if (v !== 64'h4) begin errors++; $display("FAIL timeout_status got %h exp 4", v); end
        rd(A_RUNS, v);
        checks++;
        if (v !== 64'(exp_runs)) begin errors++; $display("FAIL timeout_runs got %0d exp %0d", v, exp_runs); end
        wr(A_STATUS, 64'h1E, 8'h00);
        wr(A_LIM, 64'd0, 8'h00);
    endtask

    task automatic test_abort();
        logic [63:0] v;
        DONE = 1'b0;
        // Abort while idle has no effect.
        wr(A_CTRL, 64'h6, 8'h00);
        tick();
        rd(A_STATUS, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL abort_idle got %h exp 0", v); end
        // Abort in WAIT.
        wr(A_CTRL, 64'h5, 8'h00);
        tick();
        tick();
        tick();
        wr(A_CTRL, 64'h6, 8'h00);
        checks++;
        if (GCD_CLR !== 1'b1 || ARGS_LOCKED !== 1'b0) begin
            errors++; $display("FAIL abort_wait got clr=%b lock=%b exp 1/0", GCD_CLR, ARGS_LOCKED);
        end
        tick();
        checks++;
        if (GCD_CLR !== 1'b0) begin errors++; $display("FAIL abort_clr_width got %b exp 0", GCD_CLR); end
        rd(A_STATUS, v);
        checks++;
        if (v !== 64'h8) begin errors++; $display("FAIL abort_status got %h exp 8", v); end
        wr(A_STATUS, 64'h1E, 8'h00);
        // Abort written during LAUNCH acts in the first WAIT cycle.
        wr(A_CTRL, 64'h5, 8'h00);
        wr(A_CTRL, 64'h6, 8'h00);
        checks++;
        if (ARGS_LOCKED !== 1'b1 || GCD_CLR !== 1'b0) begin
            errors++; $display("FAIL abort_launch_wait got lock=%b clr=%b exp 1/0", ARGS_LOCKED, GCD_CLR);
        end
        tick();
        checks++;
        if (ARGS_LOCKED !== 1'b0 || GCD_CLR !== 1'b1) begin
            errors++; $display("FAIL abort_launch_exit got lock=%b clr=%b exp 0/1", ARGS_LOCKED, GCD_CLR);
        end
        wr(A_STATUS, 64'h1E, 8'h00);
        // Abort and DONE rising in the same WAIT cycle: completion wins.
        wr(A_CTRL, 64'h5, 8'h00);
        tick();
        tick();
        DONE = 1'b1;
        wr(A_CTRL, 64'h6, 8'h00);
        exp_runs++;
        checks++;
        if (ARGS_LOCKED !== 1'b0 || GCD_CLR !== 1'b0) begin
            errors++; $display("FAIL abort_vs_done got lock=%b clr=%b exp 0/0", ARGS_LOCKED, GCD_CLR);
        end
        rd(A_STATUS, v);
        checks++;
        if (v !== 64'h2) begin errors++; $display("FAIL abort_vs_done_status got %h exp 2", v); end
        wr(A_STATUS, 64'h1E, 8'h00);
        DONE = 1'b0;
        tick();
    endtask

    // START while busy, and a DONE level left high from a previous run.
    task automatic test_start_busy_stale();
        logic [63:0] v;
        DONE = 1'b1;
        tick();
        tick();
        wr(A_CTRL, 64'h5, 8'h00);
        wr(A_CTRL, 64'h5, 8'h00);
        checks++;
        if (GCD_START !== 1'b0 || ARGS_LOCKED !== 1'b1) begin
            errors++; $display("FAIL start_busy got start=%b lock=%b exp 0/1", GCD_START, ARGS_LOCKED);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (ARGS_LOCKED !== 1'b1) begin errors++; $display("FAIL stale_done got lock=%b exp 1", ARGS_LOCKED); end
        DONE = 1'b0;
        tick();
        DONE = 1'b1;
        tick();
        exp_runs++;
        checks++;
        if (ARGS_LOCKED !== 1'b0) begin errors++; $display("FAIL fresh_done got lock=%b exp 0", ARGS_LOCKED); end
        rd(A_CYCLES, v);
        checks++;
        if (v !== 64'd5) begin errors++; $display("FAIL stale_cycles got %0d exp 5", v); end
        rd(A_STATUS, v);
        checks++;
        if (v !== 64'h12) begin errors++; $display("FAIL start_err_status got %h exp 12", v); end
        wr(A_STATUS, 64'h1E, 8'h00);
        DONE = 1'b0;
        tick();
    endtask

    task automatic test_regs();
        logic [63:0] v;
        logic [63:0] old_v;
        logic [63:0] new_v;
        logic [63:0] exp_v;
        logic [7:0]  be_n;
        wr(A_LIM, 64'd0, 8'h00);
        wr(A_LIM, 64'hFFFF, 8'hFE);
        rd(A_LIM, v);
        checks++;
        if (v !== 64'hFF) begin errors++; $display("FAIL lim_byte_mask got %h exp ff", v); end
        for (int n = 0; n < 4; n++) begin
            old_v = {32'd0, $urandom};
            new_v = {$urandom, $urandom};
            be_n  = 8'($urandom);
            wr(A_LIM, old_v, 8'h00);
            wr(A_LIM, new_v, be_n);
            exp_v = old_v;
            for (int b = 0; b < 4; b++) begin
                if (!be_n[b]) exp_v[8*b +: 8] = new_v[8*b +: 8];
            end
            rd(8'h13, v);
            checks++;
            if (v !== exp_v) begin errors++; $display("FAIL lim_rand_mask got %h exp %h", v, exp_v); end
        end
        wr(8'h28, 64'hDEAD_BEEF, 8'h00);
        rd(8'h28, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL unmapped_read got %h exp 0", v); end
        // START with byte 0 disabled does nothing.
        wr(A_CTRL, 64'h5, 8'h01);
        checks++;
        if (ARGS_LOCKED !== 1'b0 || GCD_START !== 1'b0) begin
            errors++; $display("FAIL start_masked got lock=%b start=%b exp 0/0", ARGS_LOCKED, GCD_START);
        end
        wr(A_LIM, 64'd0, 8'h00);
        rd(A_CTRL, v);
        checks++;
        if (v !== 64'h4) begin errors++; $display("FAIL ctrl_read got %h exp 4", v); end
    endtask

    // Random runs: the model decides timeout vs completion from LIM and k.
    task automatic test_random_runs();
        logic [63:0] v;
        int k;
        int lim;
        int sel;
        bit exp_to;
        bit exited;
        int exp_cyc;
        for (int it = 0; it < 10; it++) begin
            k   = $urandom_range(1, 12);
            sel = $urandom_range(0, 2);
            if (sel == 0) lim = 0;
            else if (sel == 1) lim = k + 1 + $urandom_range(0, 4);
            else lim = $urandom_range(1, k);
            exp_to  = (lim != 0) && (lim <= k);
            exp_cyc = exp_to ? lim : k;
            DONE = 1'b0;
            wr(A_LIM, 64'(lim), 8'h00);
            wr(A_CTRL, 64'h5, 8'h00);
            tick();
            exited = 1'b0;
            for (int n = 0; n < 40 && !exited; n++) begin
                if (n == k) DONE = 1'b1;
                tick();
                if (ARGS_LOCKED === 1'b0) exited = 1'b1;
            end
            checks++;
            if (!exited || GCD_CLR !== exp_to) begin
                errors++; $display("FAIL rand_exit it=%0d exited=%b clr=%b exp 1/%b", it, exited, GCD_CLR, exp_to);
            end
            if (!exp_to) exp_runs++;
            rd(A_CYCLES, v);
            checks++;
            if (v !== 64'(exp_cyc)) begin errors++; $display("FAIL rand_cycles it=%0d got %0d exp %0d", it, v, exp_cyc); end
            rd(A_STATUS, v);
            checks++;
            if (v !== (exp_to ? 64'h4 : 64'h2)) begin errors++; $display("FAIL rand_status it=%0d got %h exp %h", it, v, exp_to ? 64'h4 : 64'h2); end
            rd(A_RUNS, v);
            checks++;
            if (v !== 64'(exp_runs)) begin errors++; $display("FAIL rand_runs it=%0d got %0d exp %0d", it, v, exp_runs); end
            DONE = 1'b0;
            wr(A_STATUS, 64'h1E, 8'h00);
        end
        wr(A_LIM, 64'd0, 8'h00);
    endtask

    task automatic test_reset_mid();
        logic [63:0] v;
        DONE = 1'b0;
        wr(A_CTRL, 64'h5, 8'h00);
        tick();
        tick();
        RESET = 1'b1;
        tick();
        checks++;
        if ({GCD_START, GCD_CLR, IRQ, ARGS_LOCKED} !== 4'b0000 || SRAM_RDATA !== 64'd0) begin
            errors++; $display("FAIL reset_mid got start/clr/irq/lock=%b rdata=%h exp 0000/0", {GCD_START, GCD_CLR, IRQ, ARGS_LOCKED}, SRAM_RDATA);
        end
        RESET = 1'b0;
        exp_runs = 0;
        rd(A_STATUS, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL reset_mid_status got %h exp 0", v); end
        rd(A_RUNS, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL reset_mid_runs got %h exp 0", v); end
        rd(A_CTRL, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL reset_mid_ctrl got %h exp 0", v); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_runs   = 0;
        RESET      = 1'b1;
        SRAM_CEn   = 1'b1;
        SRAM_WEn   = 1'b1;
        SRAM_WBEn  = 8'hFF;
        SRAM_ADDR  = 8'h00;
        SRAM_WDATA = 64'd0;
        DONE       = 1'b0;
        tick();
        test_reset();
        test_done_run(10);
        test_done_run(int'($urandom_range(1, 20)));
        test_timeout(5);
        test_timeout(1);
        test_abort();
        test_start_busy_stale();
        test_regs();
        test_random_runs();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
